// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: ID->EX issue control with per-register pending-write scoreboard,
// RAW/saturation stalls, fence draining and a fixed post-redirect squash window.
module hazard_scoreboard_ctrl #(
   parameter int CNT_W        = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1_idx,
   input  logic [4:0]  id_rs2_idx,
   input  logic [4:0]  id_rd_idx,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        id_writes_rd,
   input  logic        id_is_fence,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd_idx,
   input  logic        flush_i,
   output logic        id_ready,
   output logic        issue_fire,
   output logic        stall_raw,
   output logic [31:0] pending_mask,
   output logic        sb_empty,
   output logic        err_underflow,
   output logic [1:0]  state_o
);
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;
   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   state_t                    r_state, w_next;
   logic [FC_W-1:0]           r_fcnt, w_fcnt_next;
   logic [31:0][CNT_W-1:0]    r_cnt;
   logic                      r_err;
   logic [31:0]               w_inc, w_dec, w_pend;
   logic                      w_raw, w_sat;

   // Hazards look only at registered counters: a release becomes visible the cycle after wb.
   assign w_raw = (id_uses_rs1 & id_rs1_idx != 5'd0 & r_cnt[id_rs1_idx] != '0)
                | (id_uses_rs2 & id_rs2_idx != 5'd0 & r_cnt[id_rs2_idx] != '0);
   assign w_sat = id_writes_rd & id_rd_idx != 5'd0 & r_cnt[id_rd_idx] == '1;

   assign id_ready      = rst_n & r_state == RUN & !flush_i & !w_raw & !w_sat
                        & !(id_is_fence & !sb_empty);
   assign issue_fire    = id_valid & id_ready;
   assign stall_raw     = id_valid & (w_raw | w_sat);
   assign pending_mask  = w_pend;
   assign sb_empty      = ~|w_pend;
   assign err_underflow = r_err;
   assign state_o       = r_state;

   assign w_inc = (issue_fire & id_writes_rd & id_rd_idx != 5'd0) ? 32'd1 << id_rd_idx : '0;
   assign w_dec = (wb_valid & wb_rd_idx != 5'd0 & r_cnt[wb_rd_idx] != '0) ? 32'd1 << wb_rd_idx : '0;

   always_comb begin
      w_pend = '0;
      for (int r = 1; r < 32; r++) w_pend[r] = |r_cnt[r];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (w_inc[r] & !w_dec[r]) r_cnt[r] <= r_cnt[r] + 1'b1;
            else if (!w_inc[r] & w_dec[r]) r_cnt[r] <= r_cnt[r] - 1'b1;
         end
         if (wb_valid & wb_rd_idx != 5'd0 & r_cnt[wb_rd_idx] == '0) r_err <= 1'b1;
      end
   end

   always_comb begin
      w_next      = RUN;
      w_fcnt_next = r_fcnt;
      if (flush_i) begin
         w_next      = FLUSH;
         w_fcnt_next = FC_W'(FLUSH_CYCLES);
      end else begin
         case (r_state)
            RUN:     w_next = (id_valid & id_is_fence & !sb_empty) ? DRAIN : RUN;
            DRAIN:   w_next = sb_empty ? RUN : DRAIN;
            FLUSH: begin
               w_next      = (r_fcnt <= FC_W'(1)) ? RUN : FLUSH;
               w_fcnt_next = r_fcnt - 1'b1;
            end
            default: w_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_next;
         r_fcnt  <= w_fcnt_next;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl: directed stimulus for the issue/scoreboard controller.
module tb_hazard_scoreboard_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_fence, wb_valid, flush_i;
   logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx, wb_rd_idx;
   logic        id_ready, issue_fire, stall_raw, sb_empty, err_underflow;
   logic [31:0] pending_mask;
   logic [1:0]  state_o;
   int          n_pass = 0, n_total = 0;

   hazard_scoreboard_ctrl #(.CNT_W(2), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_idx(id_rs1_idx),
      .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd), .id_is_fence(id_is_fence),
      .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .flush_i(flush_i), .id_ready(id_ready),
      .issue_fire(issue_fire), .stall_raw(stall_raw), .pending_mask(pending_mask),
      .sb_empty(sb_empty), .err_underflow(err_underflow), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                         input logic w, input logic f);
      id_valid = v; id_rs1_idx = rs1; id_uses_rs1 = u1; id_rd_idx = rd;
      id_writes_rd = w; id_is_fence = f; id_rs2_idx = 5'd0; id_uses_rs2 = 1'b0;
   endtask

   task automatic wb(input logic v, input logic [4:0] rd);
      wb_valid = v; wb_rd_idx = rd;
   endtask

   initial begin
      id_set(1, 0, 0, 0, 0, 0);
      wb(0, 0);
      flush_i = 1'b0;
      #3;
      chk("rst_ready", id_ready, 0);
      chk("rst_fire", issue_fire, 0);
      chk("rst_mask", pending_mask, 0);
      chk("rst_empty", sb_empty, 1);
      chk("rst_state", state_o, 0);
      chk("rst_err", err_underflow, 0);
      tick();
      rst_n = 1'b1;
      tick();
      // RAW on x5
      id_set(1, 0, 0, 5, 1, 0); #1;
      chk("w5_fire", issue_fire, 1);
      tick();
      id_set(1, 5, 1, 6, 1, 0); #1;
      chk("w5_mask", pending_mask, 32'h20);
      chk("raw_stall", stall_raw, 1);
      chk("raw_ready", id_ready, 0);
      tick();
      wb(1, 5); #1;
      chk("raw_nobypass", stall_raw, 1);
      tick();
      wb(0, 0); #1;
      chk("raw_clear_ready", id_ready, 1);
      chk("raw_clear_fire", issue_fire, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0); wb(1, 6); #1;
      chk("x6_mask", pending_mask, 32'h40);
      tick();
      wb(0, 0); #1;
      chk("x6_empty", sb_empty, 1);
      // x0 never tracked
      id_set(1, 0, 1, 0, 1, 0); #1;
      chk("x0_ready1", id_ready, 1);
      tick(); #1;
      chk("x0_ready2", id_ready, 1);
      chk("x0_mask", pending_mask, 0);
      // saturation on x7
      id_set(1, 0, 0, 7, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("sat_fill_fire", issue_fire, 1);
         tick();
      end
      chk("sat_stall", stall_raw, 1);
      chk("sat_ready", id_ready, 0);
      wb(1, 7);
      tick();
      wb(0, 0); #1;
      chk("sat_release_fire", issue_fire, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0); wb(1, 7);
      tick(); tick(); tick();
      wb(0, 0); #1;
      chk("sat_drained", sb_empty, 1);
      // fence drains x3
      id_set(1, 0, 0, 3, 1, 0);
      tick();
      id_set(1, 0, 0, 0, 0, 1); #1;
      chk("fence_wait_ready", id_ready, 0);
      chk("fence_no_raw", stall_raw, 0);
      tick();
      chk("fence_drain", state_o, 1);
      chk("drain_ready", id_ready, 0);
      wb(1, 3);
      tick();
      wb(0, 0); #1;
      chk("drain_still", state_o, 1);
      chk("drain_empty", sb_empty, 1);
      chk("drain_ready2", id_ready, 0);
      tick();
      chk("drain_run", state_o, 0);
      chk("fence_fire", issue_fire, 1);
      // flush window and reload
      id_set(1, 0, 0, 4, 1, 0); flush_i = 1'b1; #1;
      chk("flush_nofire", issue_fire, 0);
      tick();
      flush_i = 1'b0; #1;
      chk("flush_a_state", state_o, 2);
      chk("flush_a_ready", id_ready, 0);
      chk("flush_a_mask", pending_mask, 0);
      tick();
      chk("flush_b_state", state_o, 2);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; #1;
      chk("reflush_c", state_o, 2);
      tick();
      chk("reflush_d", state_o, 2);
      chk("reflush_d_fire", issue_fire, 0);
      tick();
      chk("flush_exit", state_o, 0);
      chk("flush_exit_fire", issue_fire, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0); #1;
      chk("x4_mask", pending_mask, 32'h10);
      wb(1, 4);
      tick();
      // underflow on x9
      wb(1, 9); #1;
      chk("pre_uf_err", err_underflow, 0);
      tick();
      wb(0, 0); #1;
      chk("uf_err", err_underflow, 1);
      tick();
      chk("uf_sticky", err_underflow, 1);
      chk("uf_mask", pending_mask, 0);
      // async reset in DRAIN
      id_set(1, 0, 0, 3, 1, 0);
      tick();
      id_set(1, 0, 0, 0, 0, 1);
      tick();
      chk("pre_rst_drain", state_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", state_o, 0);
      chk("arst_err", err_underflow, 0);
      chk("arst_mask", pending_mask, 0);
      chk("arst_empty", sb_empty, 1);
      chk("arst_ready", id_ready, 0);
      tick();
      rst_n = 1'b1; #1;
      chk("post_rst_fire", issue_fire, 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
